microcode_sequencer: RTL and testbench

- Control stage directly upstream of the datapath core. Fetches an opcode over the mem bus into an instruction register (IR), then steps through that opcode's micro-steps.
- Micro-steps are looked up in an external microcode ROM, addressed by {IR, step}. Each ROM word becomes the core control word.
- Evaluates ALU flags for conditional micro-steps. Handles end-of-instruction, halt and runaway-step fault.

---
 rtl/microcode_sequencer.sv | 140 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches an opcode into IR, then walks its micro-steps from an external ROM.
// Optional single-step gating is enabled with MICROCODE_SEQUENCER_SINGLESTEP_EN.
module microcode_sequencer #(
  parameter int                 IR_W       = 8,
  parameter int                 STEP_W     = 4,
  parameter int                 CTRL_W     = 64,
  parameter logic [CTRL_W-1:0]  FETCH_WORD = {CTRL_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IR_W-1:0]        mem_in,
  input  logic [4:0]             flags,
`ifdef MICROCODE_SEQUENCER_SINGLESTEP_EN
  input  logic                   ss_mode,
  input  logic                   ss_pulse,
`endif
  output logic [IR_W+STEP_W-1:0] uaddr,
  input  logic [CTRL_W+4:0]      uword,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [IR_W-1:0]        ir_out,
  output logic [STEP_W-1:0]      step_out,
  output logic                   fetching,
  output logic                   halted,
  output logic                   fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               fault_q, fault_d;

  logic [CTRL_W-1:0]  u_ctrl;
  logic               u_end;
  logic [2:0]         u_cond;
  logic               u_halt;
  logic               cond_ok;
  logic               advance;

  assign u_ctrl = uword[CTRL_W-1:0];
  assign u_end  = uword[CTRL_W];
  assign u_cond = uword[CTRL_W+3:CTRL_W+1];
  assign u_halt = uword[CTRL_W+4];

`ifdef MICROCODE_SEQUENCER_SINGLESTEP_EN
  assign advance = !ss_mode || ss_pulse;
`else
  assign advance = 1'b1;
`endif

  // flags = {lcarry, acarry, zero, sign, overflow}
  always_comb begin
    cond_ok = 1'b0;
    case (u_cond)
      3'd0: cond_ok = 1'b1;
      3'd1: cond_ok = flags[2];
      3'd2: cond_ok = !flags[2];
      3'd3: cond_ok = flags[4];
      3'd4: cond_ok = !flags[4];
      3'd5: cond_ok = flags[1];
      3'd6: cond_ok = flags[0];
      3'd7: cond_ok = flags[3];
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    step_d   = step_q;
    fault_d  = fault_q;
    ctrl_out = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_out = FETCH_WORD;
        ir_d     = mem_in;
        step_d   = '0;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (cond_ok) ctrl_out = u_ctrl;
        // uhalt wins over uend; step overflow without uend is a runaway fault
        if (u_halt) begin
          state_d = S_HALT;
        end else if (u_end) begin
          state_d = S_FETCH;
          step_d  = '0;
        end else if (step_q == {STEP_W{1'b1}}) begin
          state_d = S_FETCH;
          step_d  = '0;
          fault_d = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_HALT: begin
        ctrl_out = '0;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // Single-step idle cycles must be invisible to the core
    if (!advance) begin
      state_d  = state_q;
      ir_d     = ir_q;
      step_d   = step_q;
      fault_d  = fault_q;
      ctrl_out = '0;
    end
    if (reset) ctrl_out = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      step_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      fault_q <= fault_d;
    end
  end

  assign uaddr    = {ir_q, step_q};
  assign ir_out   = ir_q;
  assign step_out = step_q;
  assign fetching = (state_q == S_FETCH);
  assign halted   = (state_q == S_HALT);
  assign fault    = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: a ROM image plus an instruction-level reference model,
// checked every cycle, with hand-computed literal expectations on top.
module tb_microcode_sequencer;

  localparam int IR_W   = 8;
  localparam int STEP_W = 4;
  localparam int CTRL_W = 64;
  localparam logic [CTRL_W-1:0] FW = 64'h8000_0000_0000_0013;
  localparam logic [CTRL_W-1:0] C1 = 64'hC1C1_0000_1234_5678;
  localparam logic [CTRL_W-1:0] C40A = 64'hA5A5_A5A5_0000_0001;
  localparam logic [CTRL_W-1:0] C40B = 64'h5A5A_5A5A_0000_0002;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [IR_W-1:0]        mem_in;
  logic [4:0]             flags;
  logic                   ss_mode = 1'b0;
  logic                   ss_pulse = 1'b0;
  logic [IR_W+STEP_W-1:0] uaddr;
  logic [CTRL_W+4:0]      uword;
  logic [CTRL_W-1:0]      ctrl_out;
  logic [IR_W-1:0]        ir_out;
  logic [STEP_W-1:0]      step_out;
  logic                   fetching, halted, fault;

  logic [CTRL_W+4:0] rom [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign uword = rom[uaddr];

  microcode_sequencer #(
    .IR_W(IR_W), .STEP_W(STEP_W), .CTRL_W(CTRL_W), .FETCH_WORD(FW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_in(mem_in),
    .flags(flags),
`ifdef MICROCODE_SEQUENCER_SINGLESTEP_EN
    .ss_mode(ss_mode),
    .ss_pulse(ss_pulse),
`endif
    .uaddr(uaddr),
    .uword(uword),
    .ctrl_out(ctrl_out),
    .ir_out(ir_out),
    .step_out(step_out),
    .fetching(fetching),
    .halted(halted),
    .fault(fault)
  );

  function automatic logic [CTRL_W+4:0] mkw(input logic h, input logic [2:0] c,
                                            input logic e, input logic [CTRL_W-1:0] ct);
    return {h, c, e, ct};
  endfunction

  function automatic bit cond_pass(input logic [2:0] c, input logic [4:0] f);
    bit lc, ac, z, s, ov;
    {lc, ac, z, s, ov} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return lc;
      3'd4: return !lc;
      3'd5: return s;
      3'd6: return ov;
      default: return ac;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [CTRL_W+4:0] act, input logic [CTRL_W+4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which opcode is running, which micro-step it is on, and what phase.
  string m_phase = "none";
  int    m_op = 0;
  int    m_idx = 0;
  bit    m_fault = 0;
  bit    m_valid = 0;

  always @(posedge clk) begin
    logic [CTRL_W+4:0] w;
    if (reset) begin
      m_phase = "fetch"; m_op = 0; m_idx = 0; m_fault = 0; m_valid = 1;
    end else if (m_valid && !(ss_mode && !ss_pulse)) begin
      if (m_phase == "fetch") begin
        m_op = int'(mem_in); m_idx = 0; m_phase = "exec";
      end else if (m_phase == "exec") begin
        w = rom[m_op * 16 + m_idx];
        if (w[CTRL_W+4]) m_phase = "halt";
        else if (w[CTRL_W]) begin m_phase = "fetch"; m_idx = 0; end
        else if (m_idx == 15) begin m_phase = "fetch"; m_idx = 0; m_fault = 1; end
        else m_idx = m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [CTRL_W+4:0] w;
    logic [CTRL_W-1:0] exp_ctrl;
    if (m_valid) begin
      w = rom[m_op * 16 + m_idx];
      if (reset || (ss_mode && !ss_pulse)) exp_ctrl = '0;
      else if (m_phase == "fetch") exp_ctrl = FW;
      else if (m_phase == "exec") exp_ctrl = cond_pass(w[CTRL_W+3:CTRL_W+1], flags) ? w[CTRL_W-1:0] : '0;
      else exp_ctrl = '0;
      chk("m_ctrl", ctrl_out, exp_ctrl);
      chk("m_uaddr", uaddr, (m_op * 16 + m_idx));
      chk("m_ir", ir_out, m_op);
      chk("m_step", step_out, m_idx);
      chk("m_fetching", fetching, m_phase == "fetch");
      chk("m_halted", halted, m_phase == "halt");
      chk("m_fault", fault, m_fault);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] fpat [0:7];

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    rom[12'h120] = mkw(0, 0, 1, C1);
    for (int i = 0; i < 3; i++) rom[12'h300 + i] = mkw(0, 0, i == 2, 64'h3000 + i);
    rom[12'h400] = mkw(0, 1, 0, C40A);
    rom[12'h401] = mkw(0, 1, 1, C40B);
    for (int i = 0; i < 8; i++) rom[12'h500 + i] = mkw(0, 3'(i), i == 7, 64'h5000_0000_0000_0010 + i);
    rom[12'h600] = mkw(1, 0, 1, 64'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) rom[12'h700 + i] = mkw(0, 0, i == 3, 64'h7700 + i);
    for (int i = 0; i < 16; i++) rom[12'hFF0 + i] = mkw(0, 0, 0, 64'hF0 + i);
    fpat[0] = 5'b00000; fpat[1] = 5'b00100; fpat[2] = 5'b00100; fpat[3] = 5'b10000;
    fpat[4] = 5'b10000; fpat[5] = 5'b00010; fpat[6] = 5'b00000; fpat[7] = 5'b01000;

    reset = 1'b1; mem_in = 8'h12; flags = '0;
    tick(); tick();
    @(negedge clk); chk("rst_ctrl", ctrl_out, 0);
    tick();
    reset = 1'b0;
    @(negedge clk); chk("c0_fetching", fetching, 1); chk("c0_ctrl", ctrl_out, FW);
    tick();
    mem_in = 8'h30;
    @(negedge clk); chk("c1_uaddr", uaddr, 12'h120); chk("c1_ctrl", ctrl_out, C1);
    tick();
    @(negedge clk); chk("c2_fetching", fetching, 1);
    tick();
    mem_in = 8'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("op30_step", step_out, i);
      tick();
    end
    @(negedge clk); chk("op30_done", fetching, 1);
    tick();
    flags = 5'b00000;
    @(negedge clk); chk("cond_z0_ctrl", ctrl_out, 0); chk("cond_z0_step", step_out, 0);
    tick();
    flags = 5'b00100;
    @(negedge clk); chk("cond_z1_ctrl", ctrl_out, C40B); chk("cond_z1_step", step_out, 1);
    mem_in = 8'h50;
    tick();
    tick();
    mem_in = 8'h60;
    for (int i = 0; i < 8; i++) begin
      flags = fpat[i];
      tick();
    end
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("halt_flag", halted, 1); chk("halt_ctrl", ctrl_out, 0);
      tick();
    end
    reset = 1'b1; mem_in = 8'hFF;
    tick();
    reset = 1'b0;
    @(negedge clk); chk("unhalt_fetching", fetching, 1); chk("unhalt_halted", halted, 0);
    tick();
    mem_in = 8'h12;
    repeat (16) tick();
    @(negedge clk); chk("runaway_fault", fault, 1); chk("runaway_fetch", fetching, 1);
    repeat (4) tick();
    @(negedge clk); chk("fault_sticky", fault, 1);
    reset = 1'b1; mem_in = 8'h70;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    @(negedge clk); chk("midrst_step", step_out, 2); chk("midrst_ctrl", ctrl_out, 0);
    tick();
    reset = 1'b0; mem_in = 8'h30;
    @(negedge clk);
    chk("postrst_fetch", fetching, 1); chk("postrst_ir", ir_out, 0);
    chk("postrst_step", step_out, 0); chk("postrst_fault", fault, 0);
    tick();
`ifdef MICROCODE_SEQUENCER_SINGLESTEP_EN
    ss_mode = 1'b1;
    for (int i = 0; i < 18; i++) begin
      ss_pulse = (i % 3 == 2);
      @(negedge clk);
      if (!ss_pulse) chk("ss_idle_ctrl", ctrl_out, 0);
      tick();
    end
    ss_mode = 1'b0; ss_pulse = 1'b0;
`endif
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
